// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: run/pause/done control, tick prescaler and
// carry/borrow enables for a cascade of external base-10 digit counters.
module stopwatch_ctrl #(
  parameter int TICK_DIV   = 1000000,
  parameter int NUM_DIGITS = 4,
  parameter int TICK_W     = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_stop,
  input  logic                  clear,
  input  logic                  mode_down,
  input  logic                  set_pulse,
  input  logic [1:0]            set_sel,
  input  logic [NUM_DIGITS-1:0] threshold,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  up_down,
  output logic                  clear_digits,
  output logic                  running,
  output logic                  done,
  output logic                  alarm
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);

  state_t                state_reg, state_next;
  logic [TICK_W-1:0]     presc_reg;
  logic                  tick_reg;
  logic                  dir_reg, dir_next;
  logic                  clear_digits_reg, clear_digits_next;
  logic                  alarm_reg, alarm_next;
  logic                  all_term;
  logic                  advance;
  logic                  restart;
  logic [NUM_DIGITS-1:0] carry;

  assign all_term = &threshold;

  // Ripple carry/borrow: digit i counts when every lower digit is at its terminal value.
  assign carry[0] = 1'b1;
  generate
    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_carry
      assign carry[gi] = carry[gi-1] & threshold[gi-1];
    end
  endgenerate

  always_comb begin
    state_next        = state_reg;
    dir_next          = dir_reg;
    digit_en          = '0;
    up_down           = dir_reg;
    clear_digits_next = 1'b0;
    alarm_next        = 1'b0;
    case (state_reg)
      IDLE: begin
        // Follow the requested mode so threshold shows the zero condition.
        up_down = ~mode_down;
        if (clear) begin
          clear_digits_next = 1'b1;
        end else if (start_stop) begin
          if (!(mode_down && all_term)) begin
            state_next = RUN;
            dir_next   = ~mode_down;
          end
        end else if (set_pulse) begin
          up_down = 1'b1;
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (int'(set_sel) == i) digit_en[i] = 1'b1;
          end
        end
      end
      RUN: begin
        if (tick_reg) begin
          if (all_term) begin
            state_next = DONE;
            alarm_next = 1'b1;
          end else begin
            digit_en = carry;
            if (start_stop) state_next = PAUSE;
          end
        end else if (start_stop) begin
          state_next = PAUSE;
        end
      end
      PAUSE: begin
        if (clear) begin
          state_next        = IDLE;
          clear_digits_next = 1'b1;
        end else if (start_stop) begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (clear) begin
          state_next        = IDLE;
          clear_digits_next = 1'b1;
        end else if (start_stop) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The prescaler holds on the cycle a pause is requested, so no tick is lost.
  assign advance = (state_reg == RUN) && !start_stop;
  assign restart = (state_reg == IDLE) && (state_next == RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= IDLE;
      presc_reg        <= '0;
      tick_reg         <= 1'b0;
      dir_reg          <= 1'b1;
      clear_digits_reg <= 1'b0;
      alarm_reg        <= 1'b0;
    end else begin
      state_reg        <= state_next;
      dir_reg          <= dir_next;
      clear_digits_reg <= clear_digits_next;
      alarm_reg        <= alarm_next;
      if (restart) begin
        presc_reg <= '0;
        tick_reg  <= 1'b0;
      end else if (advance) begin
        if (presc_reg == TICK_MAX) begin
          presc_reg <= '0;
          tick_reg  <= 1'b1;
        end else begin
          presc_reg <= presc_reg + TICK_W'(1);
          tick_reg  <= 1'b0;
        end
      end else begin
        tick_reg <= 1'b0;
      end
    end
  end

  assign running      = (state_reg == RUN);
  assign done         = (state_reg == DONE);
  assign clear_digits = clear_digits_reg;
  assign alarm        = alarm_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: a four-digit decimal datapath driven by
// the DUT, a value-level reference model checked every cycle, and literal checks.
module tb_stopwatch_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_stop, clear, mode_down, set_pulse;
  logic [1:0] set_sel;
  logic [3:0] threshold;
  logic [3:0] digit_en;
  logic       up_down, clear_digits, running, done, alarm;

  stopwatch_ctrl #(.TICK_DIV(TD), .NUM_DIGITS(4), .TICK_W(3)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear),
    .mode_down(mode_down), .set_pulse(set_pulse), .set_sel(set_sel),
    .threshold(threshold), .digit_en(digit_en), .up_down(up_down),
    .clear_digits(clear_digits), .running(running), .done(done), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // Digit counters: the datapath the controller sequences.
  int dg [4];
  int cyc_n = 0;

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    for (int i = 0; i < 4; i++) begin
      if (clear_digits) dg[i] <= 0;
      else if (digit_en[i]) begin
        if (up_down) dg[i] <= (dg[i] == 9) ? 0 : dg[i] + 1;
        else         dg[i] <= (dg[i] == 0) ? 9 : dg[i] - 1;
      end
    end
  end

  always_comb begin
    threshold = '0;
    for (int i = 0; i < 4; i++)
      threshold[i] = up_down ? (dg[i] == 9) : (dg[i] == 0);
  end

  function automatic int dp_val();
    return dg[0] + 10 * dg[1] + 100 * dg[2] + 1000 * dg[3];
  endfunction

  // Reference model state: time as a plain integer.
  logic m_run, m_pause, m_done, m_dir, m_pend, m_clrd, m_alarm;
  int   m_val, m_acc;
  int   en0_cnt, en1_cnt, alarm_cnt, last_en0_cyc;
  int   n_pass, n_total;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [3:0] ripple(input int v, input logic up);
    logic [3:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      r[i] = up ? ((v % p) == p - 1) : ((v % p) == 0);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int set_inc(input int v, input int sel);
    int p;
    p = 1;
    for (int i = 0; i < sel; i++) p = p * 10;
    return (((v / p) % 10) == 9) ? v - 9 * p : v + p;
  endfunction

  task automatic model_cycle();
    logic idle, term, tick_now, set_ok, ud_e, clrd_n, alarm_n, pend_n;
    logic [3:0] en_e;
    if (!rst) begin
      check("rst_running", running, 0);
      check("rst_done", done, 0);
      check("rst_digit_en", digit_en, 0);
      check("rst_clear_digits", clear_digits, 0);
      check("rst_alarm", alarm, 0);
      m_run = 0; m_pause = 0; m_done = 0; m_dir = 1; m_pend = 0;
      m_clrd = 0; m_alarm = 0; m_acc = 0;
    end else begin
      idle     = !m_run && !m_pause && !m_done;
      term     = m_dir ? (m_val == 9999) : (m_val == 0);
      tick_now = m_run && m_pend;
      set_ok   = idle && set_pulse && !clear && !start_stop;
      en_e     = '0;
      if (set_ok) en_e[set_sel] = 1'b1;
      else if (tick_now && !term) en_e = ripple(m_val, m_dir);
      ud_e = idle ? (set_ok ? 1'b1 : !mode_down) : m_dir;
      check("digit_en", digit_en, en_e);
      check("up_down", up_down, ud_e);
      check("running", running, m_run);
      check("done", done, m_done);
      check("clear_digits", clear_digits, m_clrd);
      check("alarm", alarm, m_alarm);
      check("value", dp_val(), m_val);
      if (digit_en[0]) begin en0_cnt++; last_en0_cyc = cyc_n; end
      if (digit_en[1]) en1_cnt++;
      if (alarm) alarm_cnt++;
      clrd_n = 0; alarm_n = 0;
      if (idle) begin
        if (clear) clrd_n = 1;
        else if (start_stop) begin
          if (!(mode_down && m_val == 0)) begin
            m_run = 1; m_dir = !mode_down; m_acc = 0; m_pend = 0;
          end
        end else if (set_ok) m_val = set_inc(m_val, int'(set_sel));
      end else if (m_run) begin
        pend_n = 0;
        if (!start_stop) begin
          m_acc++;
          pend_n = (m_acc % TD) == 0;
        end
        if (tick_now && term) begin
          m_run = 0; m_done = 1; alarm_n = 1;
        end else begin
          if (tick_now) m_val = m_dir ? m_val + 1 : m_val - 1;
          if (start_stop) begin m_run = 0; m_pause = 1; end
        end
        m_pend = pend_n;
      end else if (m_pause) begin
        if (clear) begin m_pause = 0; clrd_n = 1; end
        else if (start_stop) begin m_pause = 0; m_run = 1; end
      end else begin
        if (clear) begin m_done = 0; clrd_n = 1; end
        else if (start_stop) m_done = 0;
      end
      if (m_clrd) m_val = 0;
      m_clrd  = clrd_n;
      m_alarm = alarm_n;
    end
  endtask

  task automatic step(input logic s, input logic c, input logic p, input logic [1:0] sl);
    start_stop = s; clear = c; set_pulse = p; set_sel = sl;
    @(negedge clk);
    model_cycle();
    @(posedge clk); #1;
    start_stop = 0; clear = 0; set_pulse = 0; set_sel = 0;
  endtask

  task automatic idle_n(input int n);
    repeat (n) step(0, 0, 0, 2'd0);
  endtask

  initial begin
    int b0, b1, ba, r;
    n_pass = 0; n_total = 0; m_val = 0;
    en0_cnt = 0; en1_cnt = 0; alarm_cnt = 0; last_en0_cyc = 0;
    rst = 0; start_stop = 0; clear = 0; mode_down = 0; set_pulse = 0; set_sel = 0;
    @(posedge clk); #1;
    idle_n(3);
    check("reset_running", running, 0);
    check("reset_done", done, 0);
    rst = 1;
    idle_n(2);

    // Count up ten ticks from 0000.
    b0 = en0_cnt; b1 = en1_cnt;
    step(1, 0, 0, 2'd0);
    idle_n(41);
    check("up_ticks", en0_cnt - b0, 10);
    check("up_carry", en1_cnt - b1, 1);
    check("up_value", dp_val(), 10);
    step(1, 0, 0, 2'd0);
    check("pause_running", running, 0);
    step(1, 1, 0, 2'd0);
    check("prio_clear_pulse", clear_digits, 1);
    check("prio_to_idle", running, 0);
    idle_n(1);
    check("cleared_value", dp_val(), 0);

    // Pause holds the prescaler.
    step(1, 0, 0, 2'd0);
    idle_n(2);
    step(1, 0, 0, 2'd0);
    idle_n(3);
    b0 = en0_cnt;
    step(1, 0, 0, 2'd0);
    r = cyc_n;
    idle_n(3);
    check("resume_tick_count", en0_cnt - b0, 1);
    check("resume_tick_cycle", last_en0_cyc, r + 2);
    step(1, 0, 0, 2'd0);
    step(0, 1, 0, 2'd0);
    idle_n(1);

    // Countdown from zero is refused.
    mode_down = 1;
    step(1, 0, 0, 2'd0);
    check("zero_start_running", running, 0);
    idle_n(1);

    // start_stop beats set_pulse in IDLE.
    mode_down = 0;
    step(1, 0, 1, 2'd0);
    check("set_vs_start_running", running, 1);
    check("set_vs_start_value", dp_val(), 0);
    step(1, 0, 0, 2'd0);
    step(0, 1, 0, 2'd0);
    idle_n(1);

    // Countdown 0002 -> done.
    mode_down = 1;
    step(0, 0, 1, 2'd0);
    step(0, 0, 1, 2'd0);
    check("preload_value", dp_val(), 2);
    ba = alarm_cnt;
    step(1, 0, 0, 2'd0);
    idle_n(14);
    check("down_done", done, 1);
    check("down_alarm_once", alarm_cnt - ba, 1);
    check("down_no_wrap", dp_val(), 0);
    step(1, 0, 0, 2'd0);
    check("done_to_idle", done, 0);
    idle_n(1);

    // Overflow at 9999, including a set wrap on digit 0.
    mode_down = 0;
    for (int d = 0; d < 4; d++) repeat (9) step(0, 0, 1, 2'(d));
    check("preset_9999", dp_val(), 9999);
    step(0, 0, 1, 2'd0);
    check("set_wrap", dp_val(), 9990);
    repeat (9) step(0, 0, 1, 2'd0);
    ba = alarm_cnt;
    step(1, 0, 0, 2'd0);
    idle_n(6);
    check("ovf_done", done, 1);
    check("ovf_hold", dp_val(), 9999);
    check("ovf_alarm", alarm_cnt - ba, 1);
    step(0, 1, 0, 2'd0);
    idle_n(1);
    check("ovf_cleared", dp_val(), 0);

    // Asynchronous reset mid-RUN.
    step(1, 0, 0, 2'd0);
    idle_n(2);
    #2 rst = 0;
    #1;
    check("async_running", running, 0);
    check("async_digit_en", digit_en, 0);
    check("async_done", done, 0);
    idle_n(2);
    rst = 1;
    idle_n(2);
    check("post_reset_running", running, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 1000000, clk cycles per count tick (100 Hz at 100 MHz); legal range >= 2.
REQ-002 Parameter NUM_DIGITS, default 4, number of cascaded base-10 digit counters sequenced.
REQ-003 Parameter TICK_W, default 20, prescaler width; SHALL satisfy 2^TICK_W >= TICK_DIV.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start_stop  input  1  single-cycle synchronous pulse (debounced upstream).
REQ-007 clear  input  1  single-cycle synchronous pulse, clear time.
REQ-008 mode_down  input  1  level: 1 = countdown, 0 = count up; sampled at start from IDLE.
REQ-009 set_pulse  input  1  single-cycle pulse, increment the selected digit in IDLE.
REQ-010 set_sel  input  2  digit index for set_pulse; values >= NUM_DIGITS ignored.
REQ-011 threshold  input  NUM_DIGITS  per-digit terminal flag from the counters (9 when counting up, 0 when counting down).
REQ-012 digit_en  output  NUM_DIGITS  per-digit count enable.
REQ-013 up_down  output  1  direction to all digit counters, 1 = up.
REQ-014 clear_digits  output  1  registered one-cycle pulse, active-high, clears all digits.
REQ-015 running  output  1  high in RUN.
REQ-016 done  output  1  high in DONE.
REQ-017 alarm  output  1  one-cycle pulse on entry to DONE.

Function
REQ-018 FSM states SHALL be IDLE, RUN, PAUSE and DONE; the encoding is free.
REQ-019 all_term = AND of threshold; clear has priority over start_stop, and start_stop over set_pulse, in the same cycle.
REQ-020 IDLE: clear -> clear_digits pulse next cycle, stay IDLE.
REQ-021 IDLE: start_stop -> latch dir = ~mode_down and go to RUN, except when mode_down=1 and all_term=1 (time zero), where the FSM stays in IDLE.
REQ-022 IDLE: set_pulse with valid set_sel -> digit_en[set_sel]=1 for exactly that cycle with up_down=1 (the digit wraps 9->0 in the counter); no other digit is enabled.
REQ-023 In IDLE, except on a set_pulse cycle, up_down SHALL be ~mode_down so that threshold reflects the zero condition; in all other states up_down = dir.
REQ-024 RUN: start_stop -> PAUSE; clear ignored.
REQ-025 PAUSE: start_stop -> RUN; clear -> IDLE with clear_digits pulse.
REQ-026 DONE: start_stop -> IDLE (digits retained); clear -> IDLE with clear_digits pulse.
REQ-027 The prescaler SHALL count 0..TICK_DIV-1 only in RUN, be zeroed on each IDLE->RUN transition, and hold its value in PAUSE and DONE.
REQ-028 tick SHALL be a registered signal, high for one cycle when the prescaler wraps; the first tick occurs TICK_DIV cycles after entry to RUN from IDLE.
REQ-029 In RUN with tick=1 and all_term=0: digit_en[0]=1, and digit_en[i]=1 iff threshold[i-1:0] are all 1 (ripple carry/borrow); digit_en is combinational from tick, state and threshold.
REQ-030 In RUN with tick=1 and all_term=1 (9999 up or 0000 down): digit_en=0 (no wrap), go to DONE, and alarm pulses the next cycle.
REQ-031 A start_stop pulse coinciding with a tick SHALL take effect: the tick's enables still apply, then the FSM goes to PAUSE.
REQ-032 digit_en SHALL be 0 in PAUSE and DONE, and 0 in IDLE except under REQ-022.

Reset
REQ-033 While rst=0: state IDLE, prescaler 0, tick 0, dir 1, clear_digits 0, alarm 0, running 0, done 0.
REQ-034 Reset asserted mid-RUN SHALL abort immediately with no further digit_en; digit values are the datapath's responsibility.

Verification (TICK_DIV=4, NUM_DIGITS=4, counters model a base-10 cascade)
REQ-035 Count up: digits 0000, mode_down=0, start_stop -> digit_en[0] pulses every 4 cycles; after 10 ticks the digits read 0010 and the carry enables digit 1 at 0009->0010.
REQ-036 Countdown: preload 0002 via two set_pulse (set_sel=0), mode_down=1, start -> 0001, then 0000; the third tick gives done=1, a one-cycle alarm, and no wrap to 9999.
REQ-037 Zero start: digits 0000, mode_down=1, start_stop -> remains IDLE, running=0.
REQ-038 Pause: start, pause after 2 cycles, resume -> the next tick occurs 2 cycles after resume, because the prescaler is held.
REQ-039 Priority: clear and start_stop together in PAUSE -> IDLE and clear_digits=1; set_pulse with start_stop in IDLE -> RUN and no set enable.
REQ-040 Overflow: up count from 9999 -> DONE on the next tick with digit_en=0; reset asserted in RUN -> outputs reach reset values asynchronously.
